// File: rtl/mips_pkg.sv
// Shared MIPS definitions: R-type funct codes for the HI/LO unit and its FSM states.
package mips_pkg;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // True for the funct codes the multiply/divide unit executes.
    function automatic logic funct_supported(input logic [5:0] f);
        return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) ||
               (f == F_DIVU) || (f == F_MTHI)  || (f == F_MTLO);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on unsigned magnitudes.
// Multiply: acc = {partial product, remaining multiplier}, add-then-shift-right.
// Divide:   acc = {partial remainder, remaining dividend / quotient bits}, restoring shift-subtract.
module muldiv_step
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     m_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;

    // Both candidate results are formed; the operation selects one.
    always_comb begin
        sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, m_i} : '0);
        // Shifted remainder can reach WIDTH+1 bits; a set MSB of trial means a borrow.
        trial = acc_i[2*WIDTH-1:WIDTH-1] - {1'b0, m_i};
        if (is_div) begin
            if (trial[WIDTH]) begin
                acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
            end else begin
                acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning the architectural HI/LO registers.
// Accepting edge -> WIDTH iteration edges -> FIX edge -> DONE, so done rises
// WIDTH+2 edges after acceptance counting the accepting edge itself.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 negq_q, negq_d;
    logic                 negr_q, negr_d;
    logic                 isdiv_q, isdiv_d;
    logic                 dz_q, dz_d;

    logic                 accept;
    logic                 signed_op;
    logic                 sa, sb;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [2*WIDTH-1:0]   step_acc;
    logic [2*WIDTH-1:0]   prod_fix;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (state_q == S_DIV),
        .acc_i  (acc_q),
        .m_i    (m_q),
        .acc_o  (step_acc)
    );

    assign accept    = start && (state_q == S_IDLE) && funct_supported(funct) && !flush;
    assign signed_op = (funct == F_MULT) || (funct == F_DIV);
    assign sa        = signed_op && a[WIDTH-1];
    assign sb        = signed_op && b[WIDTH-1];
    assign mag_a     = magnitude(a, sa);
    assign mag_b     = magnitude(b, sb);
    assign prod_fix  = negq_q ? -acc_q : acc_q;

    // Next-state, iteration datapath and HI/LO write-back; flush overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        isdiv_d = isdiv_q;
        dz_d    = dz_q;
        if (flush) begin
            state_d = S_IDLE;
            dz_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        cnt_d   = '0;
                        negq_d  = sa ^ sb;
                        negr_d  = sa;
                        if (funct == F_MTHI) begin
                            hi_d = a;
                        end else if (funct == F_MTLO) begin
                            lo_d = a;
                        end else if ((funct == F_MULT) || (funct == F_MULTU)) begin
                            state_d = S_MUL;
                            isdiv_d = 1'b0;
                            acc_d   = {{WIDTH{1'b0}}, mag_b};
                            m_d     = mag_a;
                        end else if (b == '0) begin
                            state_d = S_DONE;
                            dz_d    = 1'b1;
                        end else begin
                            state_d = S_DIV;
                            isdiv_d = 1'b1;
                            acc_d   = {{WIDTH{1'b0}}, mag_a};
                            m_d     = mag_b;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    acc_d = step_acc;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    state_d = S_DONE;
                    if (isdiv_q) begin
                        lo_d = negq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                        hi_d = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    dz_d    = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                    dz_d    = 1'b0;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter, operand/accumulator, sign flags and HI/LO registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            isdiv_q <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            isdiv_q <= isdiv_d;
            dz_q    <= dz_d;
        end
    end

    assign busy    = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
    assign done    = (state_q == S_DONE);
    assign divzero = (state_q == S_DONE) && dz_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed plus randomized bench for muldiv_unit with an arithmetic reference model.
module tb_muldiv_unit;
    import mips_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [5:0]   funct;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         busy;
    logic         done;
    logic         divzero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int           checks;
    int           errors;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .funct   (funct),
        .a       (a),
        .b       (b),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .divzero (divzero),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Architectural result of an accepted operation, from plain 64-bit arithmetic.
    task automatic model_apply(input logic [5:0] f, input logic [W-1:0] av, input logic [W-1:0] bv);
        longint     sa;
        longint     sb;
        longint     p;
        logic [63:0] u;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        case (f)
            F_MULT: begin
                p = sa * sb;
                exp_hi = p[63:32];
                exp_lo = p[31:0];
            end
            F_MULTU: begin
                u = {32'b0, av} * {32'b0, bv};
                exp_hi = u[63:32];
                exp_lo = u[31:0];
            end
            F_DIV: begin
                if (bv != 0) begin
                    p = sa / sb;
                    exp_lo = p[31:0];
                    p = sa % sb;
                    exp_hi = p[31:0];
                end
            end
            F_DIVU: begin
                if (bv != 0) begin
                    exp_lo = av / bv;
                    exp_hi = av % bv;
                end
            end
            F_MTHI: exp_hi = av;
            F_MTLO: exp_lo = av;
            default: ;
        endcase
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_hl(input logic [5:0] f, input logic [W-1:0] v);
        start = 1'b1; funct = f; a = v; b = '0;
        step();
        start = 1'b0;
        model_apply(f, v, '0);
        check("mt_hi", hi, exp_hi);
        check("mt_lo", lo, exp_lo);
        check("mt_done", done, 0);
        check("mt_busy", busy, 0);
    endtask

    // Edges are counted with the accepting edge as edge 1.
    task automatic run_op(input logic [5:0] f, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input int flush_at, input int inj_at, input bit inj_done);
        int           n;
        bit           got;
        bit           dz_stray;
        bit           is_dz;
        int           exp_lat;
        logic [W-1:0] pre_hi;
        logic [W-1:0] pre_lo;
        pre_hi  = exp_hi;
        pre_lo  = exp_lo;
        is_dz   = ((f == F_DIV) || (f == F_DIVU)) && (bv == 0);
        exp_lat = is_dz ? 1 : W + 2;
        start = 1'b1; funct = f; a = av; b = bv;
        step();
        start = 1'b0; a = '0; b = '0;
        n = 1;
        got = done;
        dz_stray = divzero && !done;
        while (!got && n < 100 && !(flush_at > 0 && n >= W + 6)) begin
            if (n + 1 == flush_at) flush = 1'b1;
            if (n + 1 == inj_at) begin
                start = 1'b1; funct = F_MTLO; a = 32'h5A5A5A5A;
            end
            step();
            n++;
            flush = 1'b0; start = 1'b0; funct = f; a = '0;
            if (n == inj_at) begin
                check("inj_lo", lo, pre_lo);
                check("inj_busy", busy, 1);
            end
            if (divzero && !done) dz_stray = 1'b1;
            if (done) got = 1'b1;
        end
        check("divzero_without_done", dz_stray, 0);
        if (flush_at > 0) begin
            check("flush_nodone", got, 0);
            check("flush_hi", hi, pre_hi);
            check("flush_lo", lo, pre_lo);
            check("flush_busy", busy, 0);
        end else begin
            model_apply(f, av, bv);
            check("latency", n, exp_lat);
            check("res_hi", hi, exp_hi);
            check("res_lo", lo, exp_lo);
            check("res_divzero", divzero, is_dz);
            check("done_busy", busy, 0);
            if (inj_done) begin
                start = 1'b1; funct = F_MTLO; a = 32'h5A5A5A5A;
            end
            step();
            start = 1'b0; a = '0;
            check("post_done", done, 0);
            check("post_divzero", divzero, 0);
            check("post_lo", lo, exp_lo);
        end
    endtask

    initial begin
        logic [5:0]   ops [4];
        logic [5:0]   f;
        logic [W-1:0] av;
        logic [W-1:0] bv;
        int           r;
        checks = 0; errors = 0;
        exp_hi = '0; exp_lo = '0;
        ops[0] = F_MULT; ops[1] = F_MULTU; ops[2] = F_DIV; ops[3] = F_DIVU;
        reset = 1'b1; start = 1'b0; flush = 1'b0; funct = '0; a = '0; b = '0;
        #1 reset = 1'b0;
        step(); step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_divzero", divzero, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        reset = 1'b1;

        // First edge after release accepts.
        set_hl(F_MTHI, 32'hAAAA5555);
        check("mthi_const", hi, 32'hAAAA5555);

        run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1'b0);
        check("multu_hi_const", hi, 32'hFFFFFFFE);
        check("multu_lo_const", lo, 32'h00000001);
        run_op(F_MULT, 32'hFFFFFFFD, 32'h00000005, 0, 0, 1'b0);
        check("mult_lo_const", lo, 32'hFFFFFFF1);
        run_op(F_DIV, 32'hFFFFFFF9, 32'h00000002, 0, 0, 1'b0);
        check("div_lo_const", lo, 32'hFFFFFFFD);
        run_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 0, 1'b0);
        check("ovf_lo_const", lo, 32'h80000000);
        check("ovf_hi_const", hi, 32'h00000000);

        set_hl(F_MTHI, 32'h11111111);
        set_hl(F_MTLO, 32'h22222222);
        run_op(F_DIVU, 32'h00000007, 32'h00000000, 0, 0, 1'b0);
        check("dz_hi_const", hi, 32'h11111111);

        // mtlo during busy and during DONE must both be ignored.
        run_op(F_MULT, 32'h00001234, 32'hFFFF0001, 0, 6, 1'b1);
        // Abort mid-division, then abort in the completion cycle.
        run_op(F_DIV, 32'h12345678, 32'h00000321, 10, 0, 1'b0);
        run_op(F_MULTU, 32'hDEADBEEF, 32'h0000FFFF, W + 2, 0, 1'b0);

        // Flush beats start in IDLE.
        flush = 1'b1; start = 1'b1; funct = F_MTHI; a = 32'hDEADBEEF;
        step();
        flush = 1'b0; start = 1'b0;
        check("flush_vs_start_hi", hi, exp_hi);
        // Back-to-back work after the flushes.
        run_op(F_DIVU, 32'd100, 32'd7, 0, 0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            f  = ops[$urandom_range(0, 3)];
            av = $urandom;
            bv = $urandom;
            r  = $urandom_range(0, 7);
            if (r == 0) bv = '0;
            if (r == 1) bv = W'($urandom_range(1, 15));
            if (r == 2) begin av = 32'h80000000; bv = 32'hFFFFFFFF; end
            if (r == 3) av = W'($urandom_range(0, 3));
            run_op(f, av, bv, 0, 0, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset around iteration 5 of a multiply.
        start = 1'b1; funct = F_MULT; a = 32'h00C0FFEE; b = 32'h00000123;
        step();
        start = 1'b0;
        repeat (4) step();
        #2 reset = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_divzero", divzero, 0);
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        exp_hi = '0; exp_lo = '0;
        step();
        check("arst_hold_done", done, 0);
        reset = 1'b1;
        set_hl(F_MTLO, 32'h3C3C3C3C);
        run_op(F_DIV, 32'hFFFFFF9C, 32'h00000007, 0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
